// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - funct3 access-size/sign encodings
//   - FSM state type
//   - default datapath width and timeout length
//   - helper functions for access legality and store byte strobes
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int XLEN_DEF           = 64;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

    // An access is legal when exactly one direction is requested, the size
    // encoding exists for that direction, and the address is naturally aligned.
    function automatic logic lsu_access_legal(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [2:0] off
    );
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else if (rd) begin
            case (f3)
                F3_B, F3_BU: ok = 1'b1;
                F3_H, F3_HU: ok = (off[0] == 1'b0);
                F3_W, F3_WU: ok = (off[1:0] == 2'b00);
                F3_D:        ok = (off == 3'b000);
                default:     ok = 1'b0;
            endcase
        end else if (wr) begin
            case (f3)
                F3_B:    ok = 1'b1;
                F3_H:    ok = (off[0] == 1'b0);
                F3_W:    ok = (off[1:0] == 2'b00);
                F3_D:    ok = (off == 3'b000);
                default: ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Byte enables for a store of the given size placed at byte offset off.
    function automatic logic [7:0] lsu_store_strobe(
        input logic [1:0] size,
        input logic [2:0] off
    );
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            2'b11:   base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load alignment: shifts the read doubleword right by the byte
// offset, then sign- or zero-extends according to funct3. Kept stand-alone so
// a cache fill path can reuse it.
// Ports:
//   rdata  [XLEN-1:0]  raw doubleword from memory
//   off    [2:0]       byte offset within the doubleword
//   funct3 [2:0]       access size / signedness
//   data   [XLEN-1:0]  aligned, extended load value
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted_s;

    assign shifted_s = rdata >> {off, 3'b000};

    // Size/sign extension of the shifted doubleword.
    always_comb begin
        data = {XLEN{1'b0}};
        case (funct3)
            F3_B:    data = {{(XLEN-8){shifted_s[7]}},   shifted_s[7:0]};
            F3_H:    data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    data = {{(XLEN-32){shifted_s[31]}}, shifted_s[31:0]};
            F3_D:    data = shifted_s;
            F3_BU:   data = {{(XLEN-8){1'b0}},  shifted_s[7:0]};
            F3_HU:   data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
            F3_WU:   data = {{(XLEN-32){1'b0}}, shifted_s[31:0]};
            default: data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// MEM-stage load/store unit. Consumes the EX/MEM register, drives data memory
// over a req/ack handshake, extends load data and registers MEM/WB results.
// stall_o holds the upstream pipeline while an access is outstanding.
//
// Build option: define MEM_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without dmem_ack (timeout_o pulses). Without it WAIT
// persists until ack and timeout_o is tied low.
//
// Ports:
//   clk, reset (async, active-high)
//   EX/MEM in : valid_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i,
//               funct3_i, result_i, valb_i, rd_i
//   stall_o   : combinational pipeline freeze
//   dmem_*    : registered request (req/we/addr/wdata/wstrb), ack/rdata in
//   wb_*      : registered MEM/WB outputs
//   misalign_o, timeout_o : registered one-cycle error pulses
// -----------------------------------------------------------------------------
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            mem_to_reg_i,
    input  logic            reg_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] result_i,
    input  logic [XLEN-1:0] valb_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_load_data,
    output logic            misalign_o,
    output logic            timeout_o
);

    lsu_state_e      state_r;
    lsu_state_e      state_nx_s;

    logic [2:0]      off_s;
    logic            mem_op_s;
    logic            legal_s;
    logic            stall_s;
    logic            issue_s;
    logic            illegal_s;
    logic            pass_s;
    logic            complete_s;
    logic            abort_s;
    logic            timeout_hit_s;

    // Access attributes latched at issue so alignment never depends on the
    // upstream register staying frozen.
    logic [2:0]      funct3_r;
    logic [2:0]      off_r;
    logic            is_load_r;
    logic [XLEN-1:0] load_data_s;

    assign off_s    = result_i[2:0];
    assign mem_op_s = valid_i & (mem_read_i | mem_write_i);
    assign legal_s  = lsu_access_legal(mem_read_i, mem_write_i, funct3_i, off_s);

    // Reset forces the pipeline free at once, even before the first edge.
    assign stall_o  = stall_s & ~reset;

    lsu_load_align #(
        .XLEN   (XLEN)
    ) u_load_align (
        .rdata  (dmem_rdata),
        .off    (off_r),
        .funct3 (funct3_r),
        .data   (load_data_s)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TCW-1:0] to_cnt_r;
    logic           timeout_r;

    assign timeout_hit_s = (to_cnt_r == TCW'(TIMEOUT_CYCLES - 1));
    assign timeout_o     = timeout_r;

    // WAIT-cycle counter, cleared when the request is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_r <= {TCW{1'b0}};
        end else if (issue_s) begin
            to_cnt_r <= {TCW{1'b0}};
        end else if (state_r == WAIT) begin
            to_cnt_r <= to_cnt_r + {{(TCW-1){1'b0}}, 1'b1};
        end
    end

    // One-cycle pulse on an aborted access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= abort_s;
        end
    end
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (TIMEOUT_CYCLES == 32'd0);
    assign timeout_hit_s    = 1'b0;
    assign timeout_o        = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state, stall and per-cycle action decode. Ack beats timeout.
    always_comb begin
        state_nx_s = state_r;
        stall_s    = 1'b0;
        issue_s    = 1'b0;
        illegal_s  = 1'b0;
        pass_s     = 1'b0;
        complete_s = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_op_s) begin
                    if (legal_s) begin
                        issue_s    = 1'b1;
                        stall_s    = 1'b1;
                        state_nx_s = WAIT;
                    end else begin
                        illegal_s  = 1'b1;
                    end
                end else begin
                    pass_s = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    complete_s = 1'b1;
                    state_nx_s = IDLE;
                end else if (timeout_hit_s) begin
                    abort_s    = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    stall_s    = 1'b1;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Memory request registers; held stable for the whole WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= {XLEN{1'b0}};
            dmem_wdata <= {XLEN{1'b0}};
            dmem_wstrb <= 8'h00;
            funct3_r   <= 3'b000;
            off_r      <= 3'b000;
            is_load_r  <= 1'b0;
        end else if (issue_s) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_i;
            dmem_addr  <= {result_i[XLEN-1:3], 3'b000};
            dmem_wdata <= valb_i << {off_s, 3'b000};
            dmem_wstrb <= mem_write_i ? lsu_store_strobe(funct3_i[1:0], off_s) : 8'h00;
            funct3_r   <= funct3_i;
            off_r      <= off_s;
            is_load_r  <= mem_read_i;
        end else if (complete_s || abort_s) begin
            dmem_req   <= 1'b0;
        end
    end

    // MEM/WB registers and misalignment pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= 5'd0;
            wb_alu_result <= {XLEN{1'b0}};
            wb_load_data  <= {XLEN{1'b0}};
            misalign_o    <= 1'b0;
        end else begin
            misalign_o <= illegal_s;
            if (pass_s || complete_s) begin
                wb_valid      <= pass_s ? valid_i : 1'b1;
                wb_reg_write  <= reg_write_i;
                wb_mem_to_reg <= mem_to_reg_i;
                wb_rd         <= rd_i;
                wb_alu_result <= result_i;
                wb_load_data  <= (complete_s && is_load_r) ? load_data_s : {XLEN{1'b0}};
            end else if (illegal_s || abort_s) begin
                // Retire the faulting instruction without a register write.
                wb_valid      <= 1'b1;
                wb_reg_write  <= 1'b0;
                wb_mem_to_reg <= mem_to_reg_i;
                wb_rd         <= rd_i;
                wb_alu_result <= result_i;
                wb_load_data  <= {XLEN{1'b0}};
            end else begin
                wb_valid      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed-vector self-checking bench for mem_stage_lsu. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        mem_to_reg_i;
    logic        reg_write_i;
    logic [2:0]  funct3_i;
    logic [63:0] result_i;
    logic [63:0] valb_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic [63:0] wb_alu_result;
    logic [63:0] wb_load_data;
    logic        misalign_o;
    logic        timeout_o;

    int errors_r;
    int checks_r;

    mem_stage_lsu #(
        .XLEN           (64),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_i       (valid_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .mem_to_reg_i  (mem_to_reg_i),
        .reg_write_i   (reg_write_i),
        .funct3_i      (funct3_i),
        .result_i      (result_i),
        .valb_i        (valb_i),
        .rd_i          (rd_i),
        .stall_o       (stall_o),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_rd         (wb_rd),
        .wb_alu_result (wb_alu_result),
        .wb_load_data  (wb_load_data),
        .misalign_o    (misalign_o),
        .timeout_o     (timeout_o)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic m2r,
                          input logic rw, input logic [2:0] f3, input logic [63:0] res,
                          input logic [63:0] vb, input logic [4:0] dst);
        valid_i      = v;
        mem_read_i   = rd;
        mem_write_i  = wr;
        mem_to_reg_i = m2r;
        reg_write_i  = rw;
        funct3_i     = f3;
        result_i     = res;
        valb_i       = vb;
        rd_i         = dst;
        #1;
    endtask

    task automatic set_idle();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0);
    endtask

    // Load with ack in the first WAIT cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp);
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, f3, addr, 64'h0, 5'd7);
        check_eq({tag, "_stall_issue"}, {63'd0, stall_o}, 64'd1);
        tick();
        check_eq({tag, "_req"}, {63'd0, dmem_req}, 64'd1);
        check_eq({tag, "_addr"}, dmem_addr, {addr[63:3], 3'b000});
        check_eq({tag, "_bubble"}, {63'd0, wb_valid}, 64'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        #1;
        check_eq({tag, "_stall_ack"}, {63'd0, stall_o}, 64'd0);
        tick();
        dmem_ack = 1'b0;
        set_idle();
        check_eq({tag, "_req_drop"}, {63'd0, dmem_req}, 64'd0);
        check_eq({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd1);
        check_eq({tag, "_wb_rd"}, {59'd0, wb_rd}, 64'd7);
        check_eq({tag, "_data"}, wb_load_data, exp);
    endtask

    initial begin
        errors_r   = 0;
        checks_r   = 0;
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        set_idle();
        #20;
        check_eq("rst_req", {63'd0, dmem_req}, 64'd0);
        check_eq("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check_eq("rst_misalign", {63'd0, misalign_o}, 64'd0);
        check_eq("rst_timeout", {63'd0, timeout_o}, 64'd0);
        check_eq("rst_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // ALU pass-through.
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 64'h1234, 64'h0, 5'd5);
        check_eq("alu_stall", {63'd0, stall_o}, 64'd0);
        tick();
        check_eq("alu_wb_valid", {63'd0, wb_valid}, 64'd1);
        check_eq("alu_wb_rd", {59'd0, wb_rd}, 64'd5);
        check_eq("alu_wb_result", wb_alu_result, 64'h1234);
        check_eq("alu_wb_rw", {63'd0, wb_reg_write}, 64'd1);
        check_eq("alu_no_req", {63'd0, dmem_req}, 64'd0);
        set_idle();

        // Loads: offsets and extension.
        do_load("lb",  3'b000, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 3'b100, 64'h1003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        do_load("lh",  3'b001, 64'h4006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        do_load("lwu", 3'b110, 64'h4004, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF);
        do_load("lw",  3'b010, 64'h4004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        do_load("ld",  3'b011, 64'h4008, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211);

        // SH with a 3-cycle ack delay.
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 64'h2006, 64'hABCD, 5'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("sh_req", {63'd0, dmem_req}, 64'd1);
            check_eq("sh_we", {63'd0, dmem_we}, 64'd1);
            check_eq("sh_addr", dmem_addr, 64'h2000);
            check_eq("sh_wstrb", {56'd0, dmem_wstrb}, 64'hC0);
            check_eq("sh_wdata", dmem_wdata, 64'hABCD_0000_0000_0000);
            check_eq("sh_bubble", {63'd0, wb_valid}, 64'd0);
            if (i < 3) begin
                check_eq("sh_stall", {63'd0, stall_o}, 64'd1);
                tick();
            end
        end
        dmem_ack = 1'b1;
        #1;
        check_eq("sh_stall_ack", {63'd0, stall_o}, 64'd0);
        tick();
        dmem_ack = 1'b0;
        set_idle();
        check_eq("sh_req_drop", {63'd0, dmem_req}, 64'd0);
        check_eq("sh_wb_valid", {63'd0, wb_valid}, 64'd1);
        check_eq("sh_wb_rw", {63'd0, wb_reg_write}, 64'd0);
        check_eq("sh_load_data", wb_load_data, 64'h0);

        // Misaligned LW, illegal store size, read+write together.
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 64'h3002, 64'h0, 5'd9);
        check_eq("lw_mis_stall", {63'd0, stall_o}, 64'd0);
        tick();
        set_idle();
        check_eq("lw_mis_req", {63'd0, dmem_req}, 64'd0);
        check_eq("lw_mis_pulse", {63'd0, misalign_o}, 64'd1);
        check_eq("lw_mis_wb_valid", {63'd0, wb_valid}, 64'd1);
        check_eq("lw_mis_wb_rw", {63'd0, wb_reg_write}, 64'd0);
        tick();
        check_eq("mis_pulse_end", {63'd0, misalign_o}, 64'd0);
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 64'h0, 64'h0, 5'd0);
        tick();
        set_idle();
        check_eq("st_f3_mis", {63'd0, misalign_o}, 64'd1);
        check_eq("st_f3_req", {63'd0, dmem_req}, 64'd0);
        set_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0);
        tick();
        set_idle();
        check_eq("rdwr_mis", {63'd0, misalign_o}, 64'd1);

        // Ack in IDLE is ignored.
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check_eq("idle_ack_req", {63'd0, dmem_req}, 64'd0);
        check_eq("idle_ack_wb", {63'd0, wb_valid}, 64'd0);

        // Reset during WAIT.
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 64'h5000, 64'h0, 5'd3);
        tick();
        check_eq("rstw_req_before", {63'd0, dmem_req}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstw_req", {63'd0, dmem_req}, 64'd0);
        check_eq("rstw_stall", {63'd0, stall_o}, 64'd0);
        set_idle();
        @(negedge clk);
        reset = 1'b0;
        do_load("post_rst", 3'b000, 64'h6001, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F);

        // Long wait without ack.
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 64'h7000, 64'h0, 5'd4);
        tick();
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            check_eq("to_stall", {63'd0, stall_o}, 64'd1);
            tick();
            check_eq("to_not_yet", {63'd0, timeout_o}, 64'd0);
        end
        check_eq("to_stall_release", {63'd0, stall_o}, 64'd0);
        tick();
        set_idle();
        check_eq("to_pulse", {63'd0, timeout_o}, 64'd1);
        check_eq("to_req", {63'd0, dmem_req}, 64'd0);
        check_eq("to_wb_valid", {63'd0, wb_valid}, 64'd1);
        check_eq("to_wb_rw", {63'd0, wb_reg_write}, 64'd0);
        tick();
        check_eq("to_pulse_end", {63'd0, timeout_o}, 64'd0);
`else
        for (int i = 0; i < 20; i++) begin
            check_eq("wait_stall", {63'd0, stall_o}, 64'd1);
            tick();
            check_eq("wait_req", {63'd0, dmem_req}, 64'd1);
            check_eq("wait_timeout", {63'd0, timeout_o}, 64'd0);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        dmem_ack = 1'b0;
        set_idle();
        check_eq("wait_done_wb", {63'd0, wb_valid}, 64'd1);
        check_eq("wait_done_data", wb_load_data, 64'h0123_4567_89AB_CDEF);
`endif

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage load/store unit that consumes the EX/MEM pipeline register outputs and drives the data memory through a req/ack handshake.
Produces store byte strobes and aligned write data, and sign- or zero-extends load data. Registers the MEM/WB-bound results.
Holds the upstream pipeline through stall_o while a memory access is outstanding.

Parameters:
XLEN, 64, datapath and address width
TIMEOUT_CYCLES, 16, WAIT-state cycles before abort (only used with MEM_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
valid_i  input  1  EX/MEM slot holds a real instruction
mem_read_i  input  1  load
mem_write_i  input  1  store
mem_to_reg_i  input  1  writeback selects load data
reg_write_i  input  1  writeback enable
funct3_i  input  3  access size/sign
result_i  input  XLEN  effective address / ALU result
valb_i  input  XLEN  store data
rd_i  input  5  destination register
stall_o  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
dmem_req  output  1  memory request (registered)
dmem_we  output  1  1 = store
dmem_addr  output  XLEN  doubleword-aligned address {result_i[63:3],3'b0}
dmem_wdata  output  XLEN  valb_i shifted left by 8*addr[2:0]
dmem_wstrb  output  8  byte enables
dmem_ack  input  1  access complete; rdata valid this cycle for loads
dmem_rdata  input  XLEN  read doubleword
wb_valid  output  1  MEM/WB slot valid
wb_reg_write  output  1  writeback enable
wb_mem_to_reg  output  1  writeback mux select
wb_rd  output  5  destination register
wb_alu_result  output  XLEN  passed-through result_i
wb_load_data  output  XLEN  extended load data
misalign_o  output  1  one-cycle pulse, misaligned or illegal access
timeout_o  output  1  one-cycle pulse, access aborted

Behaviour:
- Reset (async): state IDLE. All registered outputs 0, including dmem_req, wb_*, misalign_o and timeout_o.
- mem_op = valid_i & (mem_read_i | mem_write_i).
- FSM states: IDLE, WAIT.
  - IDLE, no mem_op: no stall. At the next edge, wb_* take the inputs and wb_load_data = 0. Latency 1 cycle.
  - IDLE, legal mem_op: stall_o = 1. At the edge: dmem_req <= 1, dmem_we/addr/wdata/wstrb latched, state -> WAIT, wb_valid <= 0 (bubble).
  - IDLE, illegal mem_op: no request, no stall. At the edge: misalign_o <= 1, wb_valid <= 1, wb_reg_write <= 0.
  - WAIT: stall_o = !dmem_ack. dmem_* outputs are held stable.
  - WAIT, dmem_ack = 1: at the edge dmem_req <= 0, state -> IDLE, wb_valid <= 1, wb_* capture the inputs, and wb_load_data captures the extended load. Upstream advances on the same edge.
  - WAIT, dmem_ack = 0: wb_valid <= 0 each cycle.
- Minimum memory-op latency is 2 cycles (issue cycle plus ack in the first WAIT cycle).
- dmem_ack while in IDLE is ignored.
- Illegal conditions:
  - both mem_read_i and mem_write_i set;
  - load funct3 = 111, or store funct3 > 011;
  - halfword with addr[0] != 0;
  - word with addr[1:0] != 0;
  - doubleword with addr[2:0] != 0.
- Store strobes, shifted left by addr[2:0]:
  - SB 000 -> 8'h01
  - SH 001 -> 8'h03
  - SW 010 -> 8'h0F
  - SD 011 -> 8'hFF
- Load: shift dmem_rdata right by 8*addr[2:0], then extend:
  - LB 000 / LH 001 / LW 010: sign-extend from 8 / 16 / 32 bits.
  - LD 011: full 64 bits.
  - LBU 100 / LHU 101 / LWU 110: zero-extend.
- Store completion: wb_load_data = 0. wb_reg_write passes reg_write_i, which is 0 for stores.
- Reset mid-access: dmem_req drops asynchronously and state -> IDLE. The memory must tolerate the abandoned request.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a counter runs in WAIT and clears on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without dmem_ack: dmem_req <= 0, timeout_o pulses, wb_valid <= 1, wb_reg_write <= 0, stall releases, state -> IDLE.
  - Ack and timeout in the same cycle: ack wins.
- Undefined: WAIT persists indefinitely, timeout_o is tied 0 and no counter exists.

Decomposition:
- lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - the state type {IDLE, WAIT};
  - the default XLEN and default TIMEOUT_CYCLES.
- Sub-module lsu_load_align: combinational shift/extend of dmem_rdata by addr[2:0] and funct3. It is reusable by a future cache fill path.

Test Plan:
- ALU op, valid_i = 1, reg_write_i = 1, rd = 5, result = 0x1234 -> next cycle wb_valid = 1, wb_rd = 5, wb_alu_result = 0x1234, stall_o never high.
- LB at addr 0x1003, rdata = 0x0000_0000_8000_0000, ack on first WAIT cycle -> stall_o high 1 cycle, wb_load_data = 0xFFFF_FFFF_FFFF_FF80. Repeat with LBU -> 0x80.
- SH at addr 0x2006, valb = 0xABCD -> dmem_addr = 0x2000, wstrb = 8'hC0, wdata[63:48] = 0xABCD, we = 1. Outputs held stable across a 3-cycle ack delay.
- LW at addr 0x3002 -> no dmem_req, misalign_o pulse, wb_valid = 1 with wb_reg_write = 0.
- Assert reset during WAIT -> dmem_req and stall_o low immediately. The next legal load issues normally after reset release.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> timeout_o pulses 4 cycles after WAIT entry and stall_o releases.
